// File: rtl/wm_appliance_model_if.sv
// wm_appliance_model_if: actuator commands from the controller and sensor/timer feedback from the plant
interface wm_appliance_model_if;
  logic door_lock;
  logic fill_value_on;
  logic drain_value_on;
  logic motor_on;
  logic soap_wash;
  logic water_wash;
  logic done;
  logic water_filled;
  logic water_drained;
  logic add_detergent;
  logic cycle_timeout;
  logic spin_timeout;
  logic fault;
  modport master (
    output door_lock, fill_value_on, drain_value_on, motor_on, soap_wash, water_wash, done,
    input  water_filled, water_drained, add_detergent, cycle_timeout, spin_timeout, fault
  );
  modport slave (
    input  door_lock, fill_value_on, drain_value_on, motor_on, soap_wash, water_wash, done,
    output water_filled, water_drained, add_detergent, cycle_timeout, spin_timeout, fault
  );
endinterface

// File: rtl/wm_appliance_model.sv
// wm_appliance_model: washing-machine plant model (tank level, wash/spin timers, detergent dispenser)
// Define WM_FAULT_CHECK_EN to build the sticky illegal-actuator-combination fault detector.
module wm_appliance_model #(
  parameter int LEVEL_W     = 8,
  parameter int FULL_LEVEL  = 20,
  parameter int FILL_RATE   = 1,
  parameter int DRAIN_RATE  = 2,
  parameter int WASH_CYCLES = 16,
  parameter int SPIN_CYCLES = 12,
  parameter int DET_DELAY   = 3
) (
  input logic clk,
  input logic reset,
  wm_appliance_model_if.slave bus
);
  localparam int WW = $clog2(WASH_CYCLES + 1);
  localparam int SW = $clog2(SPIN_CYCLES + 1);
  localparam int DW = DET_DELAY > 1 ? $clog2(DET_DELAY) : 1;
  localparam logic [LEVEL_W:0] FL = FULL_LEVEL;
  localparam logic [LEVEL_W:0] FR = FILL_RATE;
  localparam logic [LEVEL_W:0] DR = DRAIN_RATE;
  localparam logic [WW-1:0] WC = WASH_CYCLES;
  localparam logic [SW-1:0] SC = SPIN_CYCLES;
  localparam logic [DW-1:0] DL = DET_DELAY - 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DISP = 2'd2;
  logic [LEVEL_W-1:0] lvl_q, lvl_d;
  logic [LEVEL_W:0] sum, dif;
  logic wf_q, wf_d, wd_q, wd_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic ct_q, ct_d, spt_q, spt_d;
  logic [1:0] st_q, st_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic add_q, add_d, soap_q;
  logic fill, drain, motor, soap, done;
  logic unused;
  assign fill  = bus.fill_value_on;
  assign drain = bus.drain_value_on;
  assign motor = bus.motor_on;
  assign soap  = bus.soap_wash;
  assign done  = bus.done;
  assign unused = &{1'b0, bus.water_wash, bus.door_lock, dif[LEVEL_W]};
  always_comb begin
    sum = {1'b0, lvl_q} + FR;
    dif = {1'b0, lvl_q} - DR;
    lvl_d = (fill && !drain) ? ((sum >= FL) ? FL[LEVEL_W-1:0] : sum[LEVEL_W-1:0]) :
            (drain && !fill) ? (({1'b0, lvl_q} < DR) ? '0 : dif[LEVEL_W-1:0]) : lvl_q;
    wf_d = {1'b0, lvl_d} >= FL;
    wd_d = lvl_d == '0;
    wcnt_d = (done || !motor) ? '0 : (drain || wcnt_q == WC) ? wcnt_q : wcnt_q + 1'b1;
    scnt_d = (done || !motor || !drain) ? '0 : (scnt_q == SC) ? scnt_q : scnt_q + 1'b1;
    ct_d = wcnt_d == WC;
    spt_d = scnt_d == SC;
  end
  // Dispenser: DL preload makes WAIT last exactly DET_DELAY edges.
  always_comb begin
    st_d = st_q;
    dcnt_d = dcnt_q;
    case (st_q)
      IDLE: if (soap && !soap_q) begin
        st_d = WAIT;
        dcnt_d = DL;
      end
      WAIT: if (!soap) st_d = IDLE;
            else if (dcnt_q == '0) st_d = DISP;
            else dcnt_d = dcnt_q - 1'b1;
      DISP: if (!soap) st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (done) st_d = IDLE;
    add_d = st_d == DISP;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q  <= '0;
      wf_q   <= 1'b0;
      wd_q   <= 1'b1;
      wcnt_q <= '0;
      scnt_q <= '0;
      ct_q   <= 1'b0;
      spt_q  <= 1'b0;
      st_q   <= IDLE;
      dcnt_q <= '0;
      add_q  <= 1'b0;
      soap_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      wf_q   <= wf_d;
      wd_q   <= wd_d;
      wcnt_q <= wcnt_d;
      scnt_q <= scnt_d;
      ct_q   <= ct_d;
      spt_q  <= spt_d;
      st_q   <= st_d;
      dcnt_q <= dcnt_d;
      add_q  <= add_d;
      soap_q <= soap;
    end
  end
`ifdef WM_FAULT_CHECK_EN
  logic fault_q, fault_d;
  always_comb
    fault_d = fault_q | (fill & drain) | ((motor | fill) & !bus.door_lock);
  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else fault_q <= fault_d;
  end
  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif
  assign bus.water_filled  = wf_q;
  assign bus.water_drained = wd_q;
  assign bus.add_detergent = add_q;
  assign bus.cycle_timeout = ct_q;
  assign bus.spin_timeout  = spt_q;
endmodule

// File: tb/tb_wm_appliance_model.sv
// tb_wm_appliance_model: directed checks of level, timers, dispenser, fault flag and reset
module tb_wm_appliance_model;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
`ifdef WM_FAULT_CHECK_EN
  localparam logic FEN = 1'b1;
`else
  localparam logic FEN = 1'b0;
`endif
  wm_appliance_model_if bus();
  wm_appliance_model dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_filled"}, bus.water_filled, 1'b0);
    chk({tag, "_drained"}, bus.water_drained, 1'b1);
    chk({tag, "_add"}, bus.add_detergent, 1'b0);
    chk({tag, "_cto"}, bus.cycle_timeout, 1'b0);
    chk({tag, "_sto"}, bus.spin_timeout, 1'b0);
    chk({tag, "_fault"}, bus.fault, 1'b0);
  endtask
  initial begin
    bus.door_lock = 1'b0;
    bus.fill_value_on = 1'b0;
    bus.drain_value_on = 1'b0;
    bus.motor_on = 1'b0;
    bus.soap_wash = 1'b0;
    bus.water_wash = 1'b0;
    bus.done = 1'b0;
    step(2);
    chk_reset_vals("rst");
    reset = 1'b0;
    bus.door_lock = 1'b1;
    bus.fill_value_on = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step(1);
      chk("fill_filled", bus.water_filled, k >= 20);
      chk("fill_drained", bus.water_drained, 1'b0);
    end
    bus.fill_value_on = 1'b0;
    bus.drain_value_on = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("drain_drained", bus.water_drained, k >= 10);
      chk("drain_filled", bus.water_filled, 1'b0);
    end
    bus.drain_value_on = 1'b0;
    bus.fill_value_on = 1'b1;
    step(3);
    bus.drain_value_on = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("both_drained", bus.water_drained, 1'b0);
      chk("both_filled", bus.water_filled, 1'b0);
    end
    chk("both_fault", bus.fault, FEN);
    bus.fill_value_on = 1'b0;
    step(1);
    chk("odd_drain_lvl1", bus.water_drained, 1'b0);
    step(1);
    chk("odd_drain_lvl0", bus.water_drained, 1'b1);
    step(1);
    chk("no_wrap_drained", bus.water_drained, 1'b1);
    chk("no_wrap_filled", bus.water_filled, 1'b0);
    bus.drain_value_on = 1'b0;
    bus.motor_on = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step(1);
      chk("wash_cto", bus.cycle_timeout, k >= 16);
      chk("wash_sto", bus.spin_timeout, 1'b0);
    end
    bus.drain_value_on = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("spin_cto_held", bus.cycle_timeout, 1'b1);
      chk("spin_sto", bus.spin_timeout, k >= 12);
    end
    bus.motor_on = 1'b0;
    step(1);
    chk("moff_cto", bus.cycle_timeout, 1'b0);
    chk("moff_sto", bus.spin_timeout, 1'b0);
    bus.motor_on = 1'b1;
    step(5);
    bus.drain_value_on = 1'b0;
    step(1);
    chk("spin_clr_on_drain_off", bus.spin_timeout, 1'b0);
    bus.motor_on = 1'b0;
    step(1);
    bus.motor_on = 1'b1;
    step(16);
    chk("wash2_cto", bus.cycle_timeout, 1'b1);
    bus.done = 1'b1;
    step(1);
    chk("done_cto", bus.cycle_timeout, 1'b0);
    bus.done = 1'b0;
    step(1);
    chk("after_done_cto", bus.cycle_timeout, 1'b0);
    bus.motor_on = 1'b0;
    step(1);
    bus.soap_wash = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk("det_add", bus.add_detergent, k >= 4);
    end
    bus.soap_wash = 1'b0;
    step(1);
    chk("det_release", bus.add_detergent, 1'b0);
    bus.soap_wash = 1'b1;
    step(1);
    chk("pulse_add1", bus.add_detergent, 1'b0);
    step(1);
    chk("pulse_add2", bus.add_detergent, 1'b0);
    bus.soap_wash = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("pulse_no_add", bus.add_detergent, 1'b0);
    end
    bus.water_wash = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk("rinse_no_add", bus.add_detergent, 1'b0);
    end
    bus.water_wash = 1'b0;
    bus.soap_wash = 1'b1;
    step(5);
    chk("det2_add", bus.add_detergent, 1'b1);
    bus.done = 1'b1;
    step(1);
    chk("done_add", bus.add_detergent, 1'b0);
    bus.done = 1'b0;
    step(5);
    chk("no_retrigger_add", bus.add_detergent, 1'b0);
    bus.soap_wash = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("pre_fault", bus.fault, 1'b0);
    bus.door_lock = 1'b0;
    bus.motor_on = 1'b1;
    step(1);
    bus.motor_on = 1'b0;
    bus.door_lock = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      chk("fault_sticky", bus.fault, FEN);
    end
    bus.fill_value_on = 1'b1;
    step(14);
    bus.motor_on = 1'b1;
    bus.drain_value_on = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("midspin_filled", bus.water_filled, 1'b0);
      chk("midspin_drained", bus.water_drained, 1'b0);
    end
    bus.soap_wash = 1'b1;
    step(4);
    chk("midspin_add", bus.add_detergent, 1'b1);
    reset = 1'b1;
    step(1);
    chk_reset_vals("midrst");
    reset = 1'b0;
    bus.fill_value_on = 1'b0;
    bus.drain_value_on = 1'b0;
    bus.motor_on = 1'b0;
    bus.soap_wash = 1'b0;
    step(1);
    chk("post_rst_drained", bus.water_drained, 1'b1);
    bus.fill_value_on = 1'b1;
    step(1);
    chk("post_rst_fill1", bus.water_drained, 1'b0);
    bus.fill_value_on = 1'b0;
    bus.drain_value_on = 1'b1;
    step(1);
    chk("post_rst_lvl_cleared", bus.water_drained, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
